// File: rtl/pixel_arbiter_pkg.sv
// Shared types and constants for the sprite pixel arbiter.
// Layer width and colour formats are common to the sprite blocks and the arbiter.
package pixel_arbiter_pkg;

  localparam int unsigned LAYER_W = 2;

  typedef logic [LAYER_W-1:0] layer_t;

  localparam int unsigned TRANSPARENT_DEFAULT = 0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

endpackage

// File: rtl/pixel_prio_sel.sv
// Combinational two-winner priority select: highest layer first, lowest index on ties.
// Also flags when more than two requesters compete for the two RAM ports.
module pixel_prio_sel
  import pixel_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [LAYER_W*NUM_REQ-1:0] layer,
  output logic [IDX_W-1:0]           w1_idx,
  output logic                       w1_ok,
  output logic [IDX_W-1:0]           w2_idx,
  output logic                       w2_ok,
  output logic                       over2
);

  layer_t         best1;
  layer_t         best2;
  logic [IDX_W:0] cnt;

  always_comb begin
    w1_idx = '0;
    w1_ok  = 1'b0;
    best1  = '0;
    w2_idx = '0;
    w2_ok  = 1'b0;
    best2  = '0;
    cnt    = '0;
    // Strict '>' while scanning upward keeps the lowest index on equal layers.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (!w1_ok || layer[LAYER_W*i +: LAYER_W] > best1)) begin
        w1_ok  = 1'b1;
        w1_idx = IDX_W'(i);
        best1  = layer[LAYER_W*i +: LAYER_W];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req[i] && (w1_idx != IDX_W'(i)) &&
          (!w2_ok || layer[LAYER_W*i +: LAYER_W] > best2)) begin
        w2_ok  = 1'b1;
        w2_idx = IDX_W'(i);
        best2  = layer[LAYER_W*i +: LAYER_W];
      end
      cnt = cnt + {{IDX_W{1'b0}}, req[i]};
    end
    over2 = (cnt > (IDX_W+1)'(2));
  end

endmodule

// File: rtl/pixel_arbiter.sv
// Shares the dual-port sprite pixel RAM between sprite requesters and emits one
// composited pixel per pixel slot: capture, issue, BRAM read, resolve.
module pixel_arbiter
  import pixel_arbiter_pkg::*;
#(
  parameter int unsigned       NUM_REQ     = 4,
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       DATA_W      = 12,
  parameter logic [DATA_W-1:0] TRANSPARENT = DATA_W'(TRANSPARENT_DEFAULT)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clk25en,
  input  logic                         frame_start,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [LAYER_W*NUM_REQ-1:0]   layer,
  input  logic [ADDR_W*NUM_REQ-1:0]    addr,
  input  logic [DATA_W-1:0]            bg_color,
  output logic [ADDR_W-1:0]            ram_addr_a,
  output logic [ADDR_W-1:0]            ram_addr_b,
  output logic                         ram_en_a,
  output logic                         ram_en_b,
  input  logic [DATA_W-1:0]            ram_data_a,
  input  logic [DATA_W-1:0]            ram_data_b,
  output logic [DATA_W-1:0]            pixel_out,
  output logic                         pixel_valid,
  output logic [7:0]                   drop_count,
  output logic                         proto_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                       slot_q;
  logic                       cap_valid;
  logic [NUM_REQ-1:0]         cap_req;
  logic [LAYER_W*NUM_REQ-1:0] cap_layer;
  logic [ADDR_W*NUM_REQ-1:0]  cap_addr;
  logic [ADDR_W-1:0]          cap_addr_arr [NUM_REQ];
  logic                       s1_valid, s1_va, s1_vb;
  logic                       s2_valid, s2_va, s2_vb;
  logic [IDX_W-1:0]           w1_idx, w2_idx;
  logic                       w1_ok, w2_ok, over2;

  pixel_prio_sel #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_sel (
    .req    (cap_req),
    .layer  (cap_layer),
    .w1_idx (w1_idx),
    .w1_ok  (w1_ok),
    .w2_idx (w2_idx),
    .w2_ok  (w2_ok),
    .over2  (over2)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cap_addr_arr[i] = cap_addr[ADDR_W*i +: ADDR_W];
    end
  end

  // Slot is the cycle after clk25en; requests anywhere else are protocol errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q    <= 1'b0;
      cap_valid <= 1'b0;
      cap_req   <= '0;
      cap_layer <= '0;
      cap_addr  <= '0;
      proto_err <= 1'b0;
    end else begin
      slot_q    <= clk25en;
      cap_valid <= slot_q;
      if (slot_q) begin
        cap_req   <= req;
        cap_layer <= layer;
        cap_addr  <= addr;
      end else if (|req) begin
        proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_addr_a <= '0;
      ram_addr_b <= '0;
      ram_en_a   <= 1'b0;
      ram_en_b   <= 1'b0;
      s1_valid   <= 1'b0;
      s1_va      <= 1'b0;
      s1_vb      <= 1'b0;
      s2_valid   <= 1'b0;
      s2_va      <= 1'b0;
      s2_vb      <= 1'b0;
      drop_count <= '0;
    end else begin
      ram_en_a <= cap_valid && w1_ok;
      ram_en_b <= cap_valid && w2_ok;
      if (cap_valid && w1_ok) ram_addr_a <= cap_addr_arr[w1_idx];
      if (cap_valid && w2_ok) ram_addr_b <= cap_addr_arr[w2_idx];
      s1_valid <= cap_valid;
      s1_va    <= cap_valid && w1_ok;
      s1_vb    <= cap_valid && w2_ok;
      s2_valid <= s1_valid;
      s2_va    <= s1_va;
      s2_vb    <= s1_vb;
      if (frame_start) begin
        drop_count <= '0;
      end else if (cap_valid && over2 && drop_count != 8'hFF) begin
        drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_valid <= s2_valid;
      if (s2_valid) begin
        if (s2_va && ram_data_a != TRANSPARENT) begin
          pixel_out <= ram_data_a;
        end else if (s2_vb && ram_data_b != TRANSPARENT) begin
          pixel_out <= ram_data_b;
        end else begin
          pixel_out <= bg_color;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_arbiter.sv
// Scoreboard bench for pixel_arbiter: stimulus pushes expected pixels computed from
// a ranking model; a monitor pops and compares on every pixel_valid strobe.
module tb_pixel_arbiter;

  localparam int NUM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk25en = 1'b0;
  logic        frame_start = 1'b0;
  logic [3:0]  req = '0;
  logic [7:0]  layer = '0;
  logic [31:0] addr = '0;
  logic [11:0] bg_color = '0;
  logic [7:0]  ram_addr_a, ram_addr_b;
  logic        ram_en_a, ram_en_b;
  logic [11:0] ram_data_a = '0;
  logic [11:0] ram_data_b = '0;
  logic [11:0] pixel_out;
  logic        pixel_valid;
  logic [7:0]  drop_count;
  logic        proto_err;

  pixel_arbiter #(
    .NUM_REQ (4),
    .ADDR_W  (8),
    .DATA_W  (12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clk25en     (clk25en),
    .frame_start (frame_start),
    .req         (req),
    .layer       (layer),
    .addr        (addr),
    .bg_color    (bg_color),
    .ram_addr_a  (ram_addr_a),
    .ram_addr_b  (ram_addr_b),
    .ram_en_a    (ram_en_a),
    .ram_en_b    (ram_en_b),
    .ram_data_a  (ram_data_a),
    .ram_data_b  (ram_data_b),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .drop_count  (drop_count),
    .proto_err   (proto_err)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [256];

  always @(posedge clk) begin
    if (ram_en_a) ram_data_a <= mem[ram_addr_a];
    if (ram_en_b) ram_data_b <= mem[ram_addr_b];
  end

  int          n_vec = 0;
  int          n_fail = 0;
  logic [11:0] exp_q [$];
  int          exp_drop = 0;
  logic [7:0]  exp_addr_a = '0;
  logic [7:0]  exp_addr_b = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (pixel_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL pixel_unexpected: got pixel_valid with 0x%0h, expected none at %0t",
                 pixel_out, $time);
      end else begin
        chk("pixel", 32'(pixel_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // One 4-cycle slot; the model ranks requesters by (layer, then lower index).
  task automatic slot(input logic [3:0] r, input logic [7:0] lay, input logic [31:0] ad,
                      input logic [11:0] bg, input logic fs);
    int w1 = -1, w2 = -1, b1 = -1, b2 = -1, s, n = 0;
    logic [11:0] px;
    for (int i = 0; i < NUM; i++) begin
      if (r[i]) begin
        n++;
        s = int'(lay[2*i +: 2]) * NUM + (NUM - 1 - i);
        if (s > b1) begin
          b2 = b1; w2 = w1; b1 = s; w1 = i;
        end else if (s > b2) begin
          b2 = s; w2 = i;
        end
      end
    end
    px = bg;
    if (w2 >= 0 && mem[ad[8*w2 +: 8]] != 12'h000) px = mem[ad[8*w2 +: 8]];
    if (w1 >= 0 && mem[ad[8*w1 +: 8]] != 12'h000) px = mem[ad[8*w1 +: 8]];
    if (w1 >= 0) exp_addr_a = ad[8*w1 +: 8];
    if (w2 >= 0) exp_addr_b = ad[8*w2 +: 8];
    if (fs) exp_drop = 0;
    else if (n > 2 && exp_drop < 255) exp_drop++;

    @(posedge clk); #1;
    clk25en = 1'b1; req = '0;
    @(posedge clk); #1;
    clk25en = 1'b0; req = r; layer = lay; addr = ad;
    @(posedge clk); #1;
    req = '0; bg_color = bg; frame_start = fs;
    exp_q.push_back(px);
    @(posedge clk); #1;
    frame_start = 1'b0;
    chk("ram_en_a", 32'(ram_en_a), 32'(w1 >= 0));
    chk("ram_en_b", 32'(ram_en_b), 32'(w2 >= 0));
    chk("ram_addr_a", 32'(ram_addr_a), 32'(exp_addr_a));
    chk("ram_addr_b", 32'(ram_addr_b), 32'(exp_addr_b));
    chk("drop_count", 32'(drop_count), 32'(exp_drop));
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ram_addr_a"}, 32'(ram_addr_a), 0);
    chk({tag, "_ram_addr_b"}, 32'(ram_addr_b), 0);
    chk({tag, "_ram_en"}, 32'({ram_en_a, ram_en_b}), 0);
    chk({tag, "_pixel_out"}, 32'(pixel_out), 0);
    chk({tag, "_pixel_valid"}, 32'(pixel_valid), 0);
    chk({tag, "_drop_count"}, 32'(drop_count), 0);
    chk({tag, "_proto_err"}, 32'(proto_err), 0);
  endtask

  task automatic rand_slot(input int nreq_exact);
    logic [3:0] r;
    r = 4'($urandom_range(15));
    if (nreq_exact > 0) begin
      while ($countones(r) != nreq_exact) r = 4'($urandom_range(15));
    end
    slot(r, 8'($urandom), $urandom, 12'($urandom_range(4095)),
         (nreq_exact == 0) && ($urandom_range(15) == 0));
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a] = ($urandom_range(3) == 0) ? 12'h000 : 12'($urandom);
    end
    mem[8'h10] = 12'h0F0;
    mem[8'h20] = 12'h111;
    mem[8'h30] = 12'h333;
    mem[8'h40] = 12'h000;
    mem[8'h50] = 12'hABC;

    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;

    // Single request: sprite 2, layer 1, addr 0x10.
    slot(4'b0100, 8'b00_01_00_00, 32'h00_10_00_00, 12'h777, 1'b0);
    // Sprite 0 layer 1 vs sprite 3 layer 2.
    slot(4'b1001, 8'b10_00_00_01, 32'h30_00_00_20, 12'h777, 1'b0);
    // Same layer, sprite 1 transparent, sprite 2 opaque.
    slot(4'b0110, 8'b00_10_10_00, 32'h00_50_40_00, 12'h777, 1'b0);
    // No requests: background.
    slot(4'b0000, 8'h00, 32'h0, 12'h123, 1'b0);

    for (int k = 0; k < 150; k++) rand_slot(0);

    for (int k = 0; k < 300; k++) rand_slot(3);
    chk("drop_saturated", 32'(drop_count), 255);
    // Clear wins over a drop in the same cycle.
    slot(4'b0111, 8'h1B, $urandom, 12'h456, 1'b1);
    chk("drop_cleared", 32'(drop_count), 0);

    for (int k = 0; k < 100; k++) rand_slot(0);

    // Request outside the slot cycle.
    chk("proto_err_pre", 32'(proto_err), 0);
    req = 4'b0010;
    @(posedge clk); #1;
    req = '0;
    chk("proto_err_set", 32'(proto_err), 1);
    for (int k = 0; k < 5; k++) rand_slot(0);
    chk("proto_err_sticky", 32'(proto_err), 1);

    // Reset at E2 of a valid slot: that slot's pixel must never appear.
    slot(4'b0011, 8'h0F, 32'h0000_3010, 12'h321, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    exp_drop = 0;
    exp_addr_a = '0;
    exp_addr_b = '0;
    #2;
    check_zero_outputs("midreset");
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) rand_slot(0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL pixel_missing: got %0d pending pixels, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_arbiter.md
# pixel_arbiter

Shares the sprite pixel RAM between the sprite (blob) requesters and produces one composited pixel per 25 MHz pixel slot. Each sprite block issues a one-cycle request with its layer and current RAM address. The arbiter picks the two highest-priority requests, reads both through the dual-port pixel RAM, and resolves transparency. It sits between the sprite blocks and the VGA output register, and outputs a background colour when no sprite pixel is opaque.

## Interface
- NUM_REQ, 4: number of sprite requesters (2..8).
- ADDR_W, 8: pixel RAM address width; matches the sprite address width.
- DATA_W, 12: pixel colour width (RGB444).
- TRANSPARENT, 0: colour value treated as "no pixel".

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- clk25en  in  1  pixel-slot enable, 1 cycle in 4.
- frame_start  in  1  one-cycle pulse at screen position 0,0.
- req  in  NUM_REQ  request pulses, bit i from sprite i.
- layer  in  2*NUM_REQ  layer of sprite i at [2i+1:2i]; 3 is the top layer.
- addr  in  ADDR_W*NUM_REQ  RAM address of sprite i.
- bg_color  in  DATA_W  background colour.
- ram_addr_a, ram_addr_b  out  ADDR_W  RAM port A/B address (registered).
- ram_en_a, ram_en_b  out  1  RAM port A/B read enable (registered).
- ram_data_a, ram_data_b  in  DATA_W  RAM read data; synchronous BRAM, 1-cycle latency.
- pixel_out  out  DATA_W  composited pixel.
- pixel_valid  out  1  one-cycle strobe when pixel_out updates.
- drop_count  out  8  per-frame count of slots with more than 2 requests, saturating at 255.
- proto_err  out  1  sticky; set by a request outside a pixel slot.

## Operation
- **Capture (edge E0):** requests are sampled at an edge where the registered clk25en-aligned slot is active.
  - The slot is the cycle in which the sprites' request is high (the sprites register their request on a clk25en edge).
  - The arbiter treats the cycle after clk25en as the slot; req must be zero in the other 3 cycles.
  - A nonzero req outside the slot sets proto_err and is ignored. proto_err clears only on reset.
- **Selection (combinational on the captured set):**
  - First winner w1: highest layer; ties go to the lowest index.
  - Second winner w2: same rule over the remaining requesters.
  - More than 2 requesters: drop_count increments, saturating at 255.
- **Issue (edge E1):**
  - ram_addr_a = addr[w1] and ram_en_a = 1 if w1 exists.
  - ram_addr_b = addr[w2] and ram_en_b = 1 if w2 exists.
  - Otherwise the enable is 0 and the address holds its previous value.
  - The per-port valid flags are pipelined alongside.
- **Resolve (edge E3):**
  - pixel_out = ram_data_a if port A is valid and ram_data_a != TRANSPARENT.
  - Else ram_data_b if port B is valid and opaque.
  - Else bg_color, sampled at E3.
  - pixel_valid is high for exactly one cycle.
- A slot with no requests still produces pixel_valid with bg_color.
- **Frame counter:** frame_start clears drop_count to 0 at the next edge. If a drop occurs in the same cycle, the clear wins and the count is 0, not 1.

## Timing
- Latency: req sampled at E0, ram_en at E1, BRAM output valid after E2, pixel_out and pixel_valid registered at E3. That is a fixed 3 cycles.
- Throughput: one slot per 4 cycles. The pipeline stages of consecutive slots never overlap on a RAM port.
- Reset values:
  - ram_addr_a/b = 0, ram_en_a/b = 0.
  - pixel_out = 0, pixel_valid = 0.
  - drop_count = 0, proto_err = 0.
  - All internal valid flags = 0.
- Reset asserted mid-slot: the slot is discarded and no pixel_valid follows.
- After rst_n deasserts, the first slot is captured normally.

## Structure
- Shared package pixel_arbiter_pkg holds:
  - the LAYER_W = 2 constant and layer type;
  - the TRANSPARENT default;
  - the RGB444 colour type.
- Sub-module pixel_prio_sel (combinational) takes a request vector and a layer bus and returns the w1/w2 indices and existence flags plus the count > 2 flag.
- The top level contains the capture, issue, resolve and counter registers.

## Test plan
- Single request, sprite 2 at layer 1, addr 0x10, RAM data 0x0F0 → ram_addr_a = 0x10 at E1, ram_en_b = 0, pixel_out = 0x0F0 with pixel_valid at E3.
- Sprite 0 at layer 1 and sprite 3 at layer 2, both opaque → port A reads sprite 3, pixel_out = sprite 3 data.
- Same layer, sprites 1 and 2; sprite 1 data = TRANSPARENT, sprite 2 data = 0xABC → pixel_out = 0xABC.
- No requests, bg_color = 0x123 → pixel_out = 0x123, both ram_en = 0.
- Three requests in 300 consecutive slots → drop_count = 255; frame_start → 0 next cycle.
- Request asserted in a non-slot cycle → proto_err = 1 and stays 1. Then reset asserted at E2 of a valid slot → no pixel_valid, all outputs 0.
